// File: rtl/io_stall_arbiter_pkg.sv
// Shared definitions for the I/O stall arbiter and its round-robin picker.
package io_stall_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_RESUME = 2'd2
  } state_e;

  // Requester slots in priority-ring order
  localparam int REQ_INPUT  = 0;
  localparam int REQ_OUTPUT = 1;
  localparam int REQ_LCD    = 2;
  localparam int REQ_IRQ    = 3;

endpackage

// File: rtl/io_stall_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from
// last+1, wrapping modulo N. Shared with the interrupt controller.
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] sel
);

  // Walk the ring from farthest to nearest so the nearest hit overwrites
  always_comb begin
    valid = 1'b0;
    sel   = last;
    for (int k = N; k >= 1; k--) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(last) + k) % N);
      if (req[idx]) begin
        valid = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/io_stall_arbiter.sv
// I/O stall arbiter: grants one requester the frozen-CPU window at a time,
// drives stop while granted, then holds a guard window of cpu_tick edges so
// the CPU can step past the requesting instruction.
module io_stall_arbiter
  import io_stall_arbiter_pkg::*;
#(
  parameter  int N_REQ         = 4,
  parameter  int RESUME_TICKS  = 2,
  parameter  int TIMEOUT_WIDTH = 24,
  localparam int IW            = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int RW            = (RESUME_TICKS > 0) ? $clog2(RESUME_TICKS + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_tick,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic             clr_err,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_id,
  output logic             stop,
  output logic             guard,
  output logic             timeout_err
);

  state_e                   state_q, state_d;
  logic [N_REQ-1:0]         grant_q, grant_d;
  logic [IW-1:0]            id_q, id_d;
  logic [IW-1:0]            last_q, last_d;
  logic [RW-1:0]            rcnt_q, rcnt_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic                     err_q, err_d;
  logic                     stop_q, stop_d;
  logic                     guard_q, guard_d;

  logic                     pick_valid;
  logic [IW-1:0]            pick_sel;
  logic [TIMEOUT_WIDTH-1:0] wd_inc;
  logic                     rel, tmo;

  rr_picker #(.N(N_REQ)) u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  // State register: all state and outputs are flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= IW'(N_REQ - 1);
      rcnt_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      stop_q  <= 1'b0;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      rcnt_q  <= rcnt_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      stop_q  <= stop_d;
      guard_q <= guard_d;
    end
  end

  // Next state: arbitration, release priority, watchdog and guard countdown
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    rcnt_d  = rcnt_q;
    wd_d    = wd_q;
    rel     = 1'b0;
    tmo     = 1'b0;
    // Saturating increment; release fires as the count lands on all-ones
    wd_inc  = (wd_q == '1) ? wd_q : wd_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          id_d    = pick_sel;
          wd_d    = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Owner completion beats abort beats watchdog; foreign done is ignored
        if (done[id_q])          rel = 1'b1;
        else if (!req[id_q])     rel = 1'b1;
        else if (wd_inc == '1) begin
          rel  = 1'b1;
          tmo  = 1'b1;
          wd_d = wd_inc;
        end else                 wd_d = wd_inc;
        if (rel) begin
          last_d = id_q;
          if (RESUME_TICKS == 0) state_d = ST_IDLE;
          else begin
            rcnt_d  = RW'(RESUME_TICKS);
            state_d = ST_RESUME;
          end
        end
      end
      ST_RESUME: begin
        if (cpu_tick) begin
          rcnt_d = rcnt_q - 1'b1;
          if (rcnt_q == RW'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A timeout in the same cycle as clr_err leaves the flag set
    err_d = (err_q & ~clr_err) | tmo;
  end

  // Outputs: decoded from the next state so they come straight off flops
  always_comb begin
    grant_d = '0;
    stop_d  = 1'b0;
    guard_d = (state_d == ST_RESUME);
    if (state_d == ST_GRANT) begin
      grant_d[id_d] = 1'b1;
      stop_d        = 1'b1;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign stop        = stop_q;
  assign guard       = guard_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_io_stall_arbiter.sv
// Self-checking bench for io_stall_arbiter: directed vector table, corner
// sequences (watchdog, async reset, round-robin), then random traffic
// against a behavioural reference model.
module tb_io_stall_arbiter;

  localparam int N  = 4;
  localparam int RT = 2;
  localparam int TW = 4;
  localparam int WD_LIMIT = (1 << TW) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_tick = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic       clr_err = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       stop, guard, timeout_err;

  int checks = 0;
  int errors = 0;

  io_stall_arbiter #(.N_REQ(N), .RESUME_TICKS(RT), .TIMEOUT_WIDTH(TW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_tick    (cpu_tick),
    .req         (req),
    .done        (done),
    .clr_err     (clr_err),
    .grant       (grant),
    .grant_id    (grant_id),
    .stop        (stop),
    .guard       (guard),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 = none), remaining guard ticks, cycles held
  int         m_owner, m_last, m_guard, m_held;
  logic       m_err;
  logic [1:0] m_id;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_last = N - 1; m_guard = 0; m_held = 0;
      m_err = 1'b0; m_id = 2'd0;
    end else begin
      bit tmo, rel, found;
      logic [1:0] ow;
      tmo = 0; rel = 0; found = 0;
      if (m_owner >= 0) begin
        ow = m_owner[1:0];
        if (done[ow])                  rel = 1;
        else if (!req[ow])             rel = 1;
        else if (m_held + 1 == WD_LIMIT) begin rel = 1; tmo = 1; end
        else                           m_held++;
        if (rel) begin
          m_last = m_owner; m_owner = -1; m_guard = RT;
        end
      end else if (m_guard > 0) begin
        if (cpu_tick) m_guard--;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (!found && req[i[1:0]]) begin
            found = 1; m_owner = i; m_id = i[1:0]; m_held = 0;
          end
        end
      end
      m_err = (m_err && !clr_err) || tmo;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Feed cpu ticks until the guard window closes, bounded
  task automatic wait_idle(input string name);
    for (int n = 0; n < 20 && (guard || stop); n++) begin
      cpu_tick = 1'b1;
      step();
    end
    cpu_tick = 1'b0;
    chk({name, " idle"}, int'({guard, stop}), 0);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic       tick;
    logic [3:0] eg;
    logic       es;
    logic       egd;
    logic [1:0] eid;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int cnt;
    tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0}; // first grant from 0
    tbl[1]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0}; // tick ignored in grant
    tbl[2]  = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0}; // done -> guard
    tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0}; // tick 1 of 2
    tbl[4]  = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0}; // req ignored in guard
    tbl[5]  = '{4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0}; // tick 2 -> idle
    tbl[6]  = '{4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0, 2'd3}; // grant one later
    tbl[7]  = '{4'b1000, 4'b0010, 1'b0, 4'b1000, 1'b1, 1'b0, 2'd3}; // foreign done
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3}; // abort
    tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3};
    tbl[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3};
    tbl[11] = '{4'b0101, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0}; // wrap past 3 to 0
    tbl[12] = '{4'b0101, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[13] = '{4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[14] = '{4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[15] = '{4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2}; // rotates to 2

    repeat (3) @(negedge clk);
    chk("reset outputs", int'({grant, grant_id, stop, guard, timeout_err}), 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      req = tbl[i].req; done = tbl[i].done; cpu_tick = tbl[i].tick;
      step();
      chk($sformatf("vec%0d grant/stop/guard/id/err", i),
          int'({grant, stop, guard, grant_id, timeout_err}),
          int'({tbl[i].eg, tbl[i].es, tbl[i].egd, tbl[i].eid, 1'b0}));
    end
    done = '0; cpu_tick = 1'b0;

    // Abort of owner 2 leaves no error
    req = '0;
    step();
    chk("abort no err", int'({stop, timeout_err}), 0);
    wait_idle("abort");

    // Watchdog: owner 1 never completes; clr_err coincides with the timeout
    req = 4'b0010;
    step();
    chk("wd grant", int'(grant), 4'b0010);
    cnt = 1;
    for (int n = 0; n < 40 && stop; n++) begin
      if (cnt == WD_LIMIT - 1) clr_err = 1'b1;
      step();
      if (stop) cnt++;
    end
    chk("wd grant length", cnt, WD_LIMIT);
    chk("wd err set wins", int'({timeout_err, guard, grant}), 9'h0 | {1'b1, 1'b1, 4'b0000});
    clr_err = 1'b0; req = '0;
    cpu_tick = 1'b1;
    step();
    chk("wd err sticky", int'(timeout_err), 1);
    clr_err = 1'b1;
    step();
    chk("wd err cleared", int'(timeout_err), 0);
    clr_err = 1'b0;
    wait_idle("wd");

    // Async reset mid-grant
    req = 4'b0100;
    step();
    chk("pre-reset grant", int'({grant, grant_id}), {4'b0100, 2'd2});
    #2 reset = 1'b1;
    #1 chk("async reset", int'({grant, stop, guard}), 0);
    @(negedge clk);
    reset = 1'b0;

    // Round robin from a fresh search: 0,1,2,3,0
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      step();
      chk($sformatf("rr%0d grant", r), int'({grant, grant_id}),
          int'({4'(1 << (r % 4)), 2'(r % 4)}));
      done = 4'(1 << (r % 4));
      step();
      done = '0;
      chk($sformatf("rr%0d guard", r), int'({stop, guard}), 1);
      wait_idle($sformatf("rr%0d", r));
    end

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom % 16 == 0) req[b] = ~req[b];
      if ($urandom % 5 == 0)      done = 4'(1 << $urandom_range(0, 3));
      else if ($urandom % 4 == 0) done = grant;
      else                        done = '0;
      cpu_tick = ($urandom % 3 == 0);
      clr_err  = ($urandom % 40 == 0);
      step();
      chk($sformatf("rand%0d", c),
          int'({grant, grant_id, stop, guard, timeout_err}),
          int'({(m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000, m_id,
                m_owner >= 0, m_guard > 0, m_err}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
